// File: rtl/axi_defination_pkg.sv
// axi_defination_pkg: shared AXI field types and encodings used across the codebase
package axi_defination_pkg;
  typedef logic [31:0] axi_addr_t;
  typedef logic [31:0] axi_data_t;
  typedef logic [3:0] axi_mid_t;
  typedef logic [7:0] axi_length_t;
  typedef enum logic [2:0] {SIZE_1B, SIZE_2B, SIZE_4B, SIZE_8B, SIZE_16B, SIZE_32B, SIZE_64B, SIZE_128B} axi_size_e;
  typedef enum logic [1:0] {BURST_FIXED, BURST_INCR, BURST_WRAP, BURST_RSVD} axi_burst_e;
  typedef enum logic [1:0] {RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR} axi_resp_e;
endpackage

// File: rtl/axi_burst_addr_gen.sv
// axi_burst_addr_gen: combinational next-beat address for FIXED/INCR/WRAP bursts (reserved acts as INCR)
module axi_burst_addr_gen
  import axi_defination_pkg::*;
(
  input  axi_addr_t   addr,
  input  axi_size_e   size,
  input  axi_length_t len,
  input  axi_burst_e  burst,
  output axi_addr_t   next_addr
);
  axi_addr_t step, incr, wmask;
  always_comb begin
    step = axi_addr_t'(1) << 3'(size);
    incr = (addr & ~(step - 1)) + step;
    wmask = ((axi_addr_t'(len) + 1) << 3'(size)) - 1;
    next_addr = burst == BURST_FIXED ? addr :
                burst == BURST_WRAP  ? (addr & ~wmask) | (incr & wmask) : incr;
  end
endmodule

// File: rtl/axi_slave_read_responder.sv
// axi_slave_read_responder: AXI read slave serving bursts from a preloadable word memory.
// Define AXI_RD_RESP_CHECK_EN to enable DECERR/SLVERR checking; otherwise always OKAY, memory indexed modulo depth.
module axi_slave_read_responder
  import axi_defination_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [3:0]                   arid,
  input  logic [31:0]                  araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [3:0]                   rid,
  output logic [31:0]                  rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [31:0]                  mem_wdata
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic {IDLE, BURST} state_e;
  state_e      state;
  axi_data_t   mem [MEM_DEPTH];
  axi_addr_t   cur_addr, next_addr, beat_addr;
  axi_length_t cur_len, beat;
  axi_size_e   cur_size;
  axi_burst_e  cur_burst;
  axi_resp_e   beat_resp;
  axi_data_t   beat_data;
  logic        ar_hs, r_hs;
  axi_burst_addr_gen u_addr_gen (
    .addr(cur_addr), .size(cur_size), .len(cur_len), .burst(cur_burst), .next_addr(next_addr)
  );
  assign ar_hs = arvalid & arready;
  assign r_hs = rvalid & rready;
  // Beat about to be presented: first beat comes straight from AR, later ones from the generator
  assign beat_addr = state == IDLE ? araddr : next_addr;
`ifdef AXI_RD_RESP_CHECK_EN
  axi_length_t chk_len;
  axi_size_e   chk_size;
  axi_burst_e  chk_burst;
  logic        beat_slv;
  assign chk_len = state == IDLE ? arlen : cur_len;
  assign chk_size = state == IDLE ? axi_size_e'(arsize) : cur_size;
  assign chk_burst = state == IDLE ? axi_burst_e'(arburst) : cur_burst;
  assign beat_slv = chk_size > SIZE_4B || chk_burst == BURST_RSVD ||
                    (chk_burst == BURST_WRAP && !(chk_len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  assign beat_resp = beat_slv ? RESP_SLVERR :
                     (beat_addr - BASE_ADDR) >= 32'(4 * MEM_DEPTH) ? RESP_DECERR : RESP_OKAY;
`else
  assign beat_resp = RESP_OKAY;
`endif
  assign beat_data = beat_resp != RESP_OKAY ? '0 : mem[AW'((beat_addr - BASE_ADDR) >> 2)];
  always_ff @(posedge aclk)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  always_ff @(posedge aclk)
    if (areset) begin
      state <= IDLE;
      arready <= 1'b0;
      rvalid <= 1'b0;
      rlast <= 1'b0;
      rresp <= RESP_OKAY;
      rid <= '0;
      rdata <= '0;
      beat <= '0;
    end else if (state == IDLE) begin
      arready <= !ar_hs;
      if (ar_hs) begin
        state <= BURST;
        cur_addr <= araddr;
        cur_len <= arlen;
        cur_size <= axi_size_e'(arsize);
        cur_burst <= axi_burst_e'(arburst);
        rid <= arid;
        beat <= '0;
        rvalid <= 1'b1;
        rlast <= arlen == 8'd0;
        rresp <= beat_resp;
        rdata <= beat_data;
      end
    end else if (r_hs) begin
      if (rlast) begin
        state <= IDLE;
        rvalid <= 1'b0;
        rlast <= 1'b0;
        arready <= 1'b1;
      end else begin
        cur_addr <= next_addr;
        beat <= beat + 8'd1;
        rlast <= beat + 8'd1 == cur_len;
        rresp <= beat_resp;
        rdata <= beat_data;
      end
    end
endmodule

// File: tb/tb_axi_slave_read_responder.sv
// tb_axi_slave_read_responder: directed and randomized read bursts checked against an arithmetic burst model
module tb_axi_slave_read_responder;
  logic        clk = 0, areset = 1;
  logic [3:0]  arid = 0;
  logic [31:0] araddr = 0;
  logic [7:0]  arlen = 0;
  logic [2:0]  arsize = 0;
  logic [1:0]  arburst = 0;
  logic        arvalid = 0, rready = 0, mem_we = 0;
  logic [7:0]  mem_waddr = 0;
  logic [31:0] mem_wdata = 0;
  logic        arready, rlast, rvalid;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [31:0] model_mem [256];
  int checks = 0, errors = 0;

  axi_slave_read_responder dut (
    .aclk(clk), .areset(areset), .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] bt, input int n);
    logic [31:0] bytes, al, total, lower;
    bytes = 32'd1 << size;
    al = a & ~(bytes - 1);
    total = (32'(len) + 1) * bytes;
    if (n == 0 || bt == 2'd0) return a;
    if (bt == 2'd2) begin
      lower = a - (a % total);
      return lower + ((al - lower + 32'(n) * bytes) % total);
    end
    return al + 32'(n) * bytes;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [2:0] size,
                                          input logic [7:0] len, input logic [1:0] bt);
`ifdef AXI_RD_RESP_CHECK_EN
    if (size > 3'd2 || bt == 2'd3 || (bt == 2'd2 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))) return 2'd2;
    if (a >= 32'd1024) return 2'd3;
`else
    if (size > 3'd7 || len > 8'd255 || bt > 2'd3 || a > 32'hFFFF_FFFF) return 2'd1;
`endif
    return 2'd0;
  endfunction

  function automatic logic [7:0] word_of(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return w[7:0];
  endfunction

  task automatic preload(input logic [7:0] i, input logic [31:0] d);
    mem_we = 1; mem_waddr = i; mem_wdata = d;
    @(negedge clk);
    mem_we = 0;
    model_mem[i] = d;
  endtask

  task automatic wait_arready();
    int t = 0;
    while (arready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("arready_wait", {31'd0, arready}, 32'd1);
  endtask

  task automatic check_beat(input string tag, input logic [3:0] id, input bit last,
                            input logic [1:0] er, input logic [31:0] ed);
    chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    chk({tag, "_rid"}, {28'd0, rid}, {28'd0, id});
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, {30'd0, rresp}, {30'd0, er});
    chk({tag, "_rlast"}, {31'd0, rlast}, {31'd0, last});
  endtask

  // stall_beat >= 0 stalls that beat for stall_n cycles; -2 gives random stalls on every beat
  task automatic burst(input string tag, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input int stall_beat,
                       input int stall_n, input bit collide);
    logic [31:0] ba, ed;
    logic [1:0]  er;
    logic [7:0]  w;
    int k;
    wait_arready();
    arvalid = 1; arid = id; araddr = a; arlen = len; arsize = size; arburst = bt; rready = 0;
    @(negedge clk);
    arvalid = 0;
    for (int n = 0; n <= int'(len); n++) begin
      ba = beat_addr(a, size, len, bt, n);
      w = word_of(ba);
      er = exp_resp(ba, size, len, bt);
      ed = er != 2'd0 ? 32'd0 : model_mem[w];
      check_beat(tag, id, n == int'(len), er, ed);
      k = n == stall_beat ? stall_n : stall_beat == -2 ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < k; s++) begin
        rready = 0;
        if (collide && s == 0) begin
          mem_we = 1; mem_waddr = w; mem_wdata = ~model_mem[w];
        end
        @(negedge clk);
        if (mem_we) begin
          mem_we = 0;
          model_mem[w] = mem_wdata;
        end
        check_beat({tag, "_stall"}, id, n == int'(len), er, ed);
      end
      rready = 1;
      @(negedge clk);
      rready = 0;
    end
    chk({tag, "_end_rvalid"}, {31'd0, rvalid}, 32'd0);
    chk({tag, "_end_arready"}, {31'd0, arready}, 32'd1);
  endtask

  initial begin
    logic [1:0] bt;
    logic [7:0] len;
    logic [2:0] size;
    repeat (2) @(negedge clk);
    chk("rst_arready", {31'd0, arready}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rlast", {31'd0, rlast}, 32'd0);
    chk("rst_rid", {28'd0, rid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_rresp", {30'd0, rresp}, 32'd0);
    areset = 0;
    @(negedge clk);
    chk("post_rst_arready", {31'd0, arready}, 32'd1);
    for (int i = 0; i < 256; i++) preload(8'(i), $urandom);

    preload(8'd4, 32'hDEAD_BEEF);
    burst("single", 4'd3, 32'h10, 8'd0, 3'd2, 2'd1, -1, 0, 1'b0);
    for (int i = 0; i < 4; i++) preload(8'(i), 32'(i));
    burst("incr_bp", 4'd5, 32'h0, 8'd3, 3'd2, 2'd1, 1, 2, 1'b0);
    burst("wrap", 4'd6, 32'h38, 8'd3, 3'd2, 2'd2, -1, 0, 1'b0);
    burst("fixed_coll", 4'd7, 32'h8, 8'd2, 3'd2, 2'd0, 0, 2, 1'b1);
    burst("top_edge", 4'd8, 32'd1020, 8'd1, 3'd2, 2'd1, -1, 0, 1'b0);
    burst("rsvd", 4'd9, 32'h20, 8'd2, 3'd2, 2'd3, -1, 0, 1'b0);
    burst("sub_word", 4'd10, 32'h41, 8'd4, 3'd0, 2'd1, -1, 0, 1'b0);
`ifdef AXI_RD_RESP_CHECK_EN
    burst("wrap_bad", 4'd11, 32'h30, 8'd2, 3'd2, 2'd2, -1, 0, 1'b0);
`endif

    wait_arready();
    arvalid = 1; arid = 4'd2; araddr = 32'h40; arlen = 8'd7; arsize = 3'd2; arburst = 2'd1;
    @(negedge clk);
    arvalid = 0; rready = 1;
    @(negedge clk);
    rready = 0;
    chk("mid_beat1_rdata", rdata, model_mem[17]);
    areset = 1;
    @(negedge clk);
    chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("mid_rst_arready", {31'd0, arready}, 32'd0);
    areset = 0; rready = 1;
    @(negedge clk);
    rready = 0;
    chk("mid_rel_arready", {31'd0, arready}, 32'd1);
    chk("mid_rel_rvalid", {31'd0, rvalid}, 32'd0);
    burst("after_rst", 4'd4, 32'h80, 8'd2, 3'd2, 2'd1, -1, 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      bt = 2'($urandom_range(0, 2));
      size = 3'($urandom_range(0, 2));
      len = bt == 2'd2 ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 7));
      burst("rand", 4'($urandom), 32'($urandom_range(0, 1023)), len, size, bt, -2, 0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
